// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU control and multiply sequencer.
// Holds funct codes, ALU select codes, HiLo writeback unit-select codes, FSM state
// and accumulate-mode encodings, plus small decode helpers.
package alu_ctrl_pkg;

  // Instruction funct field codes
  localparam logic [5:0] FunctAdd   = 6'b100000;
  localparam logic [5:0] FunctSub   = 6'b100010;
  localparam logic [5:0] FunctAnd   = 6'b100100;
  localparam logic [5:0] FunctOr    = 6'b100101;
  localparam logic [5:0] FunctSlt   = 6'b101010;
  localparam logic [5:0] FunctSrl   = 6'b000010;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctMaddu = 6'b011100;
  localparam logic [5:0] FunctMsubu = 6'b000101;
  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMflo  = 6'b010010;

  // ALU operation select codes
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // Unit-select codes driven during HiLo writeback
  localparam logic [5:0] MultuOut = 6'b111111;
  localparam logic [5:0] MadduOut = 6'b111110;
  localparam logic [5:0] MsubuOut = 6'b111101;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWb
  } mul_state_e;

  typedef enum logic [1:0] {
    AccOverwrite = 2'b00,
    AccAdd       = 2'b01,
    AccSub       = 2'b10
  } acc_mode_e;

  function automatic logic is_mul_class(logic [5:0] funct);
    return (funct == FunctMult) || (funct == FunctMultu) ||
           (funct == FunctMaddu) || (funct == FunctMsubu);
  endfunction

  function automatic logic is_hilo_read(logic [5:0] funct);
    return (funct == FunctMfhi) || (funct == FunctMflo);
  endfunction

  function automatic acc_mode_e acc_of(logic [5:0] funct);
    if (funct == FunctMaddu) return AccAdd;
    if (funct == FunctMsubu) return AccSub;
    return AccOverwrite;
  endfunction

  // MULT and MULTU share the overwrite writeback code
  function automatic logic [5:0] out_code(acc_mode_e acc);
    case (acc)
      AccAdd:  return MadduOut;
      AccSub:  return MsubuOut;
      default: return MultuOut;
    endcase
  endfunction

endpackage

// File: rtl/mul_seq_fsm.sv
// Multiply-class op sequencer: IDLE -> RUN (CYCLES iterations) -> WB.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   issue_i           mul-class op present in EX this cycle
//   funct_i           funct field, used to latch signedness / accumulate mode
//   flush_i           cancel in-flight op (RUN or WB)
//   mul_start_o       one-cycle pulse in the first RUN cycle
//   mul_signed_o      1 for MULT, held for the whole op
//   acc_mode_o        accumulate mode, held for the whole op
//   hilo_we_o         HiLo write strobe (WB cycle)
//   busy_o            state != IDLE
//   wb_enter_o        the coming edge moves RUN -> WB
module mul_seq_fsm
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CYCLES = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_i,
  input  logic [5:0] funct_i,
  input  logic       flush_i,
  output logic       mul_start_o,
  output logic       mul_signed_o,
  output logic [1:0] acc_mode_o,
  output logic       hilo_we_o,
  output logic       busy_o,
  output logic       wb_enter_o
);

  localparam int unsigned CNT_W = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CYCLES - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             signed_q, signed_d;
  acc_mode_e        acc_q, acc_d;

  // Flush wins over the RUN -> WB transition
  assign wb_enter_o = (state_q == StRun) && (cnt_q == CntLast) && !flush_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    signed_d = signed_q;
    acc_d    = acc_q;
    unique case (state_q)
      StIdle: begin
        if (issue_i) begin
          state_d  = StRun;
          cnt_d    = '0;
          start_d  = 1'b1;
          signed_d = (funct_i == FunctMult);
          acc_d    = acc_of(funct_i);
        end
      end
      StRun: begin
        if (flush_i) begin
          state_d  = StIdle;
          cnt_d    = '0;
          signed_d = 1'b0;
          acc_d    = AccOverwrite;
        end else if (cnt_q == CntLast) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        // Leaves after one cycle whether or not flushed
        state_d  = StIdle;
        cnt_d    = '0;
        signed_d = 1'b0;
        acc_d    = AccOverwrite;
      end
      default: begin
        state_d  = StIdle;
        cnt_d    = '0;
        signed_d = 1'b0;
        acc_d    = AccOverwrite;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      signed_q <= 1'b0;
      acc_q    <= AccOverwrite;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      signed_q <= signed_d;
      acc_q    <= acc_d;
    end
  end

  assign mul_start_o  = start_q;
  assign mul_signed_o = signed_q;
  assign acc_mode_o   = acc_q;
  assign hilo_we_o    = (state_q == StWb);
  assign busy_o       = (state_q != StIdle);

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control with iterative multiply sequencing.
// Decodes alu_op/funct into alu_sel, drives the registered unit_sel bus for the
// shifter/multiplier/output mux, and stalls IF/ID/EX while a multiply-class op or
// a HiLo read would collide with an in-flight multiply.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   alu_op, funct     main-control ALUOp and instruction funct field
//   nop               EX slot is a bubble
//   flush             cancel in-flight multiply op
//   alu_sel, illegal  combinational decode
//   unit_sel          registered unit select
//   mul_start, mul_signed, acc_mode, hilo_we, busy   multiply sequencer outputs
//   stall             combinational pipeline freeze
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CYCLES = DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  input  logic       nop,
  input  logic       flush,
  output logic [2:0] alu_sel,
  output logic       illegal,
  output logic [5:0] unit_sel,
  output logic       mul_start,
  output logic       mul_signed,
  output logic [1:0] acc_mode,
  output logic       hilo_we,
  output logic       busy,
  output logic       stall
);

  logic       issue;
  logic       wb_enter;
  logic [5:0] unit_sel_q, unit_sel_d;

  always_comb begin
    alu_sel = AluAdd;
    illegal = 1'b0;
    unique case (alu_op)
      2'b00: alu_sel = AluAdd;
      2'b01: alu_sel = AluSub;
      2'b10: begin
        case (funct)
          FunctAdd: alu_sel = AluAdd;
          FunctSub: alu_sel = AluSub;
          FunctAnd: alu_sel = AluAnd;
          FunctOr:  alu_sel = AluOr;
          FunctSlt: alu_sel = AluSlt;
          // Known non-ALU functs are routed by unit_sel; ALU idles on add
          FunctSrl, FunctMult, FunctMultu, FunctMaddu, FunctMsubu,
          FunctMfhi, FunctMflo: alu_sel = AluAdd;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign issue = (alu_op == 2'b10) && !nop && is_mul_class(funct);

  // Only ops touching the multiplier or HiLo wait; everything else flows past
  assign stall = busy && !nop && (is_mul_class(funct) || is_hilo_read(funct));

  mul_seq_fsm #(
    .CYCLES(CYCLES)
  ) u_mul_seq_fsm (
    .clk_i       (clk),
    .rst_i       (rst),
    .issue_i     (issue),
    .funct_i     (funct),
    .flush_i     (flush),
    .mul_start_o (mul_start),
    .mul_signed_o(mul_signed),
    .acc_mode_o  (acc_mode),
    .hilo_we_o   (hilo_we),
    .busy_o      (busy),
    .wb_enter_o  (wb_enter)
  );

  always_comb begin
    unit_sel_d = unit_sel_q;
    if (wb_enter) begin
      unit_sel_d = out_code(acc_mode_e'(acc_mode));
    end else if (!nop && !stall) begin
      unit_sel_d = funct;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) unit_sel_q <= '0;
    else     unit_sel_q <= unit_sel_d;
  end

  assign unit_sel = unit_sel_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

  localparam int unsigned CYCLES = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       nop;
  logic       flush;
  logic [2:0] alu_sel;
  logic       illegal;
  logic [5:0] unit_sel;
  logic       mul_start;
  logic       mul_signed;
  logic [1:0] acc_mode;
  logic       hilo_we;
  logic       busy;
  logic       stall;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  code;
    logic [1:0]  acc;
  } wb_exp_t;

  wb_exp_t sb[$];

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] fn;
    logic [2:0] sel;
    logic       ill;
  } dec_t;

  dec_t dec_tab [9] = '{
    '{2'b10, 6'b100000, 3'b010, 1'b0},
    '{2'b10, 6'b100010, 3'b110, 1'b0},
    '{2'b10, 6'b100100, 3'b000, 1'b0},
    '{2'b10, 6'b100101, 3'b001, 1'b0},
    '{2'b10, 6'b101010, 3'b111, 1'b0},
    '{2'b00, 6'b100100, 3'b010, 1'b0},
    '{2'b01, 6'b100101, 3'b110, 1'b0},
    '{2'b11, 6'b100000, 3'b010, 1'b1},
    '{2'b10, 6'b111000, 3'b010, 1'b1}
  };

  alu_ctrl_seq #(
    .DATA_W(32),
    .CYCLES(CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_op    (alu_op),
    .funct     (funct),
    .nop       (nop),
    .flush     (flush),
    .alu_sel   (alu_sel),
    .illegal   (illegal),
    .unit_sel  (unit_sel),
    .mul_start (mul_start),
    .mul_signed(mul_signed),
    .acc_mode  (acc_mode),
    .hilo_we   (hilo_we),
    .busy      (busy),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mul-class op now; its writeback is expected CYCLES+1 cycles after the edge
  task automatic issue(input logic [5:0] fn, input logic [5:0] code, input logic [1:0] acc);
    wb_exp_t e;
    alu_op = 2'b10;
    funct  = fn;
    nop    = 1'b0;
    e.cyc  = cyc + CYCLES + 1;
    e.code = code;
    e.acc  = acc;
    sb.push_back(e);
  endtask

  // Writeback monitor: every hilo_we must match the oldest outstanding op
  always @(negedge clk) begin
    if (!rst && hilo_we) begin
      if (sb.size() == 0) begin
        check("hilo_we_unexpected", 32'(hilo_we), 32'd0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check("wb_cycle", cyc, e.cyc);
        check("wb_unit_sel", 32'(unit_sel), 32'(e.code));
        check("wb_acc_mode", 32'(acc_mode), 32'(e.acc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alu_op = 2'b10; funct = 6'b100000; nop = 1'b1; flush = 1'b0;
    tick();
    tick();
    check("rst_unit_sel", 32'(unit_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_hilo_we", 32'(hilo_we), 32'd0);
    check("rst_acc_mode", 32'(acc_mode), 32'd0);
    rst = 1'b0;
    tick();

    // Decode sweep with the slot empty
    foreach (dec_tab[i]) begin
      alu_op = dec_tab[i].op;
      funct  = dec_tab[i].fn;
      #1;
      check($sformatf("dec_sel_%0d", i), 32'(alu_sel), 32'(dec_tab[i].sel));
      check($sformatf("dec_ill_%0d", i), 32'(illegal), 32'(dec_tab[i].ill));
    end
    tick();

    // MULTU, then ADD flows past while busy
    issue(6'b011001, 6'b111111, 2'b00);
    tick();
    check("multu_start", 32'(mul_start), 32'd1);
    check("multu_busy1", 32'(busy), 32'd1);
    check("multu_signed", 32'(mul_signed), 32'd0);
    check("multu_acc", 32'(acc_mode), 32'd0);
    check("multu_us_issue", 32'(unit_sel), 32'h19);
    funct = 6'b100000;
    tick();
    check("multu_start_pulse", 32'(mul_start), 32'd0);
    check("multu_us_add", 32'(unit_sel), 32'h20);
    for (int k = 3; k <= int'(CYCLES); k++) tick();
    check("multu_busy32", 32'(busy), 32'd1);
    check("multu_we32", 32'(hilo_we), 32'd0);
    tick();
    check("multu_we33", 32'(hilo_we), 32'd1);
    check("multu_us33", 32'(unit_sel), 32'h3f);
    check("multu_stall33", 32'(stall), 32'd0);
    tick();
    check("multu_busy34", 32'(busy), 32'd0);
    check("multu_we34", 32'(hilo_we), 32'd0);
    check("multu_us34", 32'(unit_sel), 32'h20);

    // MSUBU then MFLO: MFLO stalls through WB
    issue(6'b000101, 6'b111101, 2'b10);
    tick();
    check("msubu_start", 32'(mul_start), 32'd1);
    check("msubu_acc", 32'(acc_mode), 32'd2);
    funct = 6'b010010;
    #1;
    check("msubu_stall1", 32'(stall), 32'd1);
    for (int k = 2; k <= int'(CYCLES) + 1; k++) begin
      tick();
      check($sformatf("msubu_stall%0d", k), 32'(stall), 32'd1);
    end
    check("msubu_us_wb", 32'(unit_sel), 32'h3d);
    tick();
    check("msubu_stall_idle", 32'(stall), 32'd0);
    check("msubu_busy_idle", 32'(busy), 32'd0);
    tick();
    check("mflo_us", 32'(unit_sel), 32'h12);

    // MADDU, then ADD while busy
    issue(6'b011100, 6'b111110, 2'b01);
    tick();
    funct = 6'b100000;
    #1;
    check("maddu_add_nostall", 32'(stall), 32'd0);
    tick();
    check("maddu_us_add", 32'(unit_sel), 32'h20);
    check("maddu_busy", 32'(busy), 32'd1);
    nop = 1'b1;
    for (int k = 3; k <= int'(CYCLES) + 1; k++) tick();
    check("maddu_us_wb", 32'(unit_sel), 32'h3e);
    tick();
    check("maddu_busy_end", 32'(busy), 32'd0);

    // MULT flushed at cnt=10
    issue(6'b011000, 6'b111111, 2'b00);
    tick();
    check("mult_signed", 32'(mul_signed), 32'd1);
    nop = 1'b1;
    for (int k = 2; k <= 11; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_signed", 32'(mul_signed), 32'd0);
    check("flush_we", 32'(hilo_we), 32'd0);
    sb.delete(sb.size() - 1);
    for (int k = 0; k < 40; k++) tick();

    issue(6'b011001, 6'b111111, 2'b00);
    tick();
    nop = 1'b1;
    for (int k = 2; k <= int'(CYCLES); k++) tick();
    check("post_flush_busy32", 32'(busy), 32'd1);
    check("post_flush_we32", 32'(hilo_we), 32'd0);
    tick();
    check("post_flush_we33", 32'(hilo_we), 32'd1);
    tick();
    check("post_flush_busy34", 32'(busy), 32'd0);

    // Reset in the middle of RUN
    issue(6'b011001, 6'b111111, 2'b00);
    tick();
    nop = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    sb.delete(sb.size() - 1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_start", 32'(mul_start), 32'd0);
    check("mrst_signed", 32'(mul_signed), 32'd0);
    check("mrst_acc", 32'(acc_mode), 32'd0);
    check("mrst_we", 32'(hilo_we), 32'd0);
    check("mrst_us", 32'(unit_sel), 32'd0);
    check("mrst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();
    issue(6'b011001, 6'b111111, 2'b00);
    tick();
    check("rerun_start", 32'(mul_start), 32'd1);
    nop = 1'b1;
    for (int k = 2; k <= int'(CYCLES); k++) tick();
    check("rerun_we32", 32'(hilo_we), 32'd0);
    tick();
    check("rerun_we33", 32'(hilo_we), 32'd1);
    tick();
    check("rerun_busy34", 32'(busy), 32'd0);

    for (int k = 0; k < 4; k++) tick();
    check("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised successor to the pipeline ALU control unit. It decodes ALUOp/funct into ALU select codes and drives a registered unit-select bus for the shifter, multiplier and output mux. It also sequences iterative multiply-class ops (MULT, MULTU, MADDU, MSUBU) with a cycle counter, HiLo write strobe and pipeline stall. It sits in the EX stage beside the ALU, multiplier and HiLo register.

Parameters:
DATA_W, 32, operand width; informational, drives default of CYCLES
CYCLES, DATA_W, multiplier iterations per op; legal range 2..64
CNT_W, $clog2(CYCLES), counter width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alu_op  in  2  main-control ALUOp
funct  in  6  instruction funct field
nop  in  1  bubble in EX; when 1 the slot carries no instruction
flush  in  1  cancel any in-flight multiply op
alu_sel  out  3  ALU operation code (combinational)
illegal  out  1  alu_op=10 with unknown funct, or alu_op=11 (combinational)
unit_sel  out  6  registered select to SHT/MUL/MUX
mul_start  out  1  one-cycle pulse: multiplier loads operands
mul_signed  out  1  1 for MULT; held for the whole op
acc_mode  out  2  00 overwrite, 01 HiLo+=prod, 10 HiLo-=prod; held for the whole op
hilo_we  out  1  one-cycle HiLo write strobe
busy  out  1  state != IDLE
stall  out  1  freeze IF/ID/EX (combinational)

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. Reset is the only initialisation; there are no initial blocks.
- Funct codes: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SRL 000010, MULT 011000, MULTU 011001, MADDU 011100, MSUBU 000101, MFHI 010000, MFLO 010010.
- Out codes: MULTU_OUT 111111 (also used for MULT), MADDU_OUT 111110, MSUBU_OUT 111101.
- alu_sel mapping:
  - alu_op 00 -> 010 (add); 01 -> 110 (sub).
  - alu_op 10 decodes funct: ADD 010, SUB 110, AND 000, OR 001, SLT 111.
  - Any other combination -> 010 with illegal=1. alu_sel is never X.
- Mul-class op: alu_op=10, nop=0, funct in {MULT, MULTU, MADDU, MSUBU}.
- FSM states: IDLE, RUN, WB.
  - IDLE: a mul-class op at the edge -> RUN, cnt=0. In the next cycle mul_start=1, and mul_signed/acc_mode latch from funct.
  - RUN: cnt increments each cycle. cnt==CYCLES-1 at the edge -> WB.
  - WB: hilo_we=1 and unit_sel=matching *_OUT code for exactly one cycle, then -> IDLE.
- Latency: with issue sampled at edge E0, hilo_we is high in the cycle after edge E0+CYCLES.
- unit_sel register:
  - rst -> 000000.
  - Entering WB -> *_OUT code.
  - Otherwise, if nop=0 and stall=0 -> funct; else hold.
- stall = busy & ~nop & (funct is mul-class or MFHI/MFLO). Stall is also high in WB. Non-HiLo ops proceed while busy.
- A mul-class op stalled during RUN/WB is accepted at the first edge in IDLE. There are no back-to-back overlaps.
- flush in RUN or WB -> IDLE at the edge. No hilo_we, no *_OUT; cnt and latched modes clear. flush in IDLE has no effect. flush has priority over the WB transition; rst has priority over flush.
- Reset mid-operation: all outputs 0, state IDLE, cnt 0 at the next edge.
- After the rst edge, all registered outputs are 0: mul_start, mul_signed, acc_mode, hilo_we, busy, unit_sel.
- Counter never wraps. It is compared against CYCLES-1 only in RUN.

Decomposition:
- Package alu_ctrl_pkg holds:
  - funct code constants
  - ALU code constants
  - *_OUT constants
  - FSM state enum (IDLE/RUN/WB)
  - acc_mode encoding
- One sub-module, mul_seq_fsm, holds the FSM, counter, mul_start/hilo_we/latched modes and the busy output. The top holds alu_sel decode, stall and the unit_sel register.

Test Plan:
- Decode sweep: alu_op=10 with each ALU funct -> alu_sel 010/110/000/001/111, illegal=0. alu_op=11 -> alu_sel=010, illegal=1. funct=111000 with alu_op=10 -> illegal=1.
- MULTU with CYCLES=32, issued at edge 0 -> mul_start high in cycle 1, busy cycles 1..33, hilo_we and unit_sel=111111 in cycle 33 only, acc_mode=00, mul_signed=0.
- MSUBU then MFLO next cycle -> stall=1 until WB ends. hilo_we with acc_mode=10, unit_sel=111101. MFLO enters unit_sel (010010) one cycle after WB.
- MADDU, then ADD while busy -> ADD not stalled, unit_sel=100000 next cycle. MADDU_OUT 111110 still appears in WB.
- flush at cnt=10 of MULT -> busy drops next cycle, hilo_we never asserts. A following MULTU runs a full 32 cycles.
- rst asserted mid-RUN while nop=1 -> all outputs 0 after the edge. A MULTU presented after rst deasserts restarts the count from 0.
